enet_mii_rx: RTL and testbench

// - Receive half of the 10/100 MAC. Samples the PHY MII receive nibbles, strips preamble/SFD and packs

---
 rtl/enet_mii_defs.sv | 28 ++
 rtl/enet_crc32_d8.sv | 30 +++
 rtl/enet_mii_rx.sv | 218 +++++++++++++++++++++
 tb/tb_enet_mii_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_mii_defs.sv
// Shared MII definitions for the 10/100 MAC rx and tx paths.
package enet_mii_defs;

  localparam logic [3:0]  NB_PREAMBLE   = 4'h5;
  localparam logic [3:0]  NB_SFD        = 4'hD;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StFrame,
    StFlush,
    StDrop
  } rx_state_e;

  // One byte of Ethernet CRC-32; wire order is LSB first, so data bits are fed 0..7.
  function automatic logic [31:0] nextCRC32_D8(input logic [7:0] data, input logic [31:0] crc);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/enet_crc32_d8.sv
// Byte-wide CRC-32 register with synchronous init and enable.
module enet_crc32_d8
  import enet_mii_defs::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  // Next CRC value: init wins over a byte update.
  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = 32'hFFFFFFFF;
    else if (en_i) crc_d = nextCRC32_D8(data_i, crc_q);
  end

  // CRC state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= 32'hFFFFFFFF;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/enet_mii_rx.sv
// MII receive path: strips preamble/SFD, packs bytes into 32-bit little-endian words, checks FCS.
module enet_mii_rx
  import enet_mii_defs::*;
#(
  parameter int unsigned MAX_FRAME = 1522
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  mii_rxd_i,
  input  logic        mii_rx_dv_i,
  input  logic        mii_rx_er_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  strb_o,
  output logic        last_o,
  output logic        crc_ok_o,
  output logic        error_o
);

  logic [3:0]  rxd_q;
  logic        dv_q, er_q;
  rx_state_e   state_q, state_d;
  logic [3:0]  lo_q, lo_d;
  logic        nib_hi_q, nib_hi_d;
  logic [31:0] acc_q, acc_d, hold_q, hold_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic        hold_v_q, hold_v_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d, last_q, last_d, crc_ok_q, crc_ok_d, error_q, error_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d, acc_strb;
  logic        crc_init, crc_en;
  logic [7:0]  byte_in;
  logic [31:0] crc;

  assign byte_in = {rxd_q, lo_q};

  enet_crc32_d8 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (byte_in),
    .crc_o  (crc)
  );

  // Byte enables for a partially filled accumulator.
  always_comb begin
    acc_strb = 4'h7;
    case (acc_cnt_q)
      2'd1:    acc_strb = 4'h1;
      2'd2:    acc_strb = 4'h3;
      default: acc_strb = 4'h7;
    endcase
  end

  // Next-state, packing and output decode.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    nib_hi_d   = nib_hi_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    crc_ok_d   = 1'b0;
    error_d    = 1'b0;
    data_d     = data_q;
    strb_d     = strb_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (dv_q && rxd_q == NB_PREAMBLE) state_d = StPreamble;
      end
      StPreamble: begin
        if (!dv_q) begin
          state_d = StIdle;
        end else if (rxd_q == NB_SFD) begin
          state_d    = StFrame;
          crc_init   = 1'b1;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          nib_hi_d   = 1'b0;
          acc_d      = '0;
          acc_cnt_d  = '0;
          hold_v_d   = 1'b0;
        end else if (rxd_q != NB_PREAMBLE) begin
          state_d = StIdle;
        end
      end
      StFrame: begin
        if (!dv_q) begin
          state_d = StFlush;
          // Trailing low nibble without its partner is discarded and flagged.
          if (nib_hi_q) err_d = 1'b1;
        end else begin
          if (er_q) err_d = 1'b1;
          if (!nib_hi_q) begin
            lo_d     = rxd_q;
            nib_hi_d = 1'b1;
          end else begin
            nib_hi_d = 1'b0;
            if (byte_cnt_q == 16'(MAX_FRAME)) begin
              // Overlength: keep the held word so it can still carry last_o.
              err_d   = 1'b1;
              state_d = StDrop;
            end else begin
              crc_en     = 1'b1;
              byte_cnt_d = byte_cnt_q + 16'd1;
              if (hold_v_q) begin
                valid_d  = 1'b1;
                data_d   = hold_q;
                strb_d   = 4'hF;
                hold_v_d = 1'b0;
              end
              if (acc_cnt_q == 2'd3) begin
                hold_d    = {byte_in, acc_q[23:0]};
                hold_v_d  = 1'b1;
                acc_d     = '0;
                acc_cnt_d = '0;
              end else begin
                acc_d[{acc_cnt_q, 3'b000} +: 8] = byte_in;
                acc_cnt_d = acc_cnt_q + 2'd1;
              end
            end
          end
        end
      end
      StDrop: begin
        if (!dv_q)     state_d = StFlush;
        else if (er_q) err_d   = 1'b1;
      end
      StFlush: begin
        if (hold_v_q) begin
          valid_d  = 1'b1;
          data_d   = hold_q;
          strb_d   = 4'hF;
          hold_v_d = 1'b0;
          if (acc_cnt_q == 2'd0) begin
            last_d   = 1'b1;
            crc_ok_d = (crc == CRC32_RESIDUE);
            error_d  = err_q;
            state_d  = StIdle;
          end
        end else begin
          if (acc_cnt_q != 2'd0) begin
            valid_d  = 1'b1;
            data_d   = acc_q;
            strb_d   = acc_strb;
            last_d   = 1'b1;
            crc_ok_d = (crc == CRC32_RESIDUE);
            error_d  = err_q;
          end
          acc_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Input capture, FSM and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_q      <= '0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      state_q    <= StIdle;
      lo_q       <= '0;
      nib_hi_q   <= 1'b0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rxd_q      <= mii_rxd_i;
      dv_q       <= mii_rx_dv_i;
      er_q       <= mii_rx_er_i;
      state_q    <= state_d;
      lo_q       <= lo_d;
      nib_hi_q   <= nib_hi_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      last_q     <= last_d;
      crc_ok_q   <= crc_ok_d;
      error_q    <= error_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign strb_o   = strb_q;
  assign last_o   = last_q;
  assign crc_ok_o = crc_ok_q;
  assign error_o  = error_q;

endmodule

// File: tb/tb_enet_mii_rx.sv
// Bench for enet_mii_rx: frame table driven into a default and a MAX_FRAME=64 instance.
module tb_enet_mii_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rxd = '0;
  logic        dv  = 1'b0;
  logic        er  = 1'b0;
  logic        valid [2];
  logic [31:0] data  [2];
  logic [3:0]  strb  [2];
  logic        last  [2];
  logic        crc_ok[2];
  logic        error [2];

  enet_mii_rx u_dut (
    .clk_i(clk), .rst_i(rst), .mii_rxd_i(rxd), .mii_rx_dv_i(dv), .mii_rx_er_i(er),
    .valid_o(valid[0]), .data_o(data[0]), .strb_o(strb[0]), .last_o(last[0]),
    .crc_ok_o(crc_ok[0]), .error_o(error[0])
  );

  enet_mii_rx #(.MAX_FRAME(64)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .mii_rxd_i(rxd), .mii_rx_dv_i(dv), .mii_rx_er_i(er),
    .valid_o(valid[1]), .data_o(data[1]), .strb_o(strb[1]), .last_o(last[1]),
    .crc_ok_o(crc_ok[1]), .error_o(error[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int nbytes;   // including FCS
    bit flip;     // corrupt a payload bit after FCS generation
    int er_byte;  // byte carrying rx_er, -1 for none
    bit odd;      // append one stray nibble
    bit er_pre;   // rx_er during preamble
    int gap;      // dv-low nibbles after the frame
  } vec_t;

  localparam int NV = 9;
  vec_t        vecs  [NV];
  vec_t        frames[16];
  logic [7:0]  exp_b [16][128];
  int          t_b4  [16];
  int          drv_cyc;
  int          n_chk = 0;
  int          n_fail = 0;

  // Monitor state, per instance
  int          cur_n [2];
  int          cur_first[2];
  logic [31:0] cur_w [2][32];
  int          done  [2];
  int          r_n   [2][16];
  int          r_first[2][16];
  logic [31:0] r_w   [2][16][32];
  logic [3:0]  r_strb[2][16];
  logic        r_crc [2][16];
  logic        r_err [2][16];

  initial begin
    for (int g = 0; g < 2; g++) begin
      cur_n[g] = 0;
      done[g]  = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        cur_n[g] = 0;
      end else if (valid[g]) begin
        if (cur_n[g] == 0) cur_first[g] = cyc;
        if (cur_n[g] < 32) cur_w[g][cur_n[g]] = data[g];
        cur_n[g]++;
        if (last[g]) begin
          if (done[g] < 16) begin
            r_n[g][done[g]]     = cur_n[g];
            r_first[g][done[g]] = cur_first[g];
            r_strb[g][done[g]]  = strb[g];
            r_crc[g][done[g]]   = crc_ok[g];
            r_err[g][done[g]]   = error[g];
            for (int w = 0; w < 32; w++) r_w[g][done[g]][w] = cur_w[g][w];
          end
          done[g]++;
          cur_n[g] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nib(input logic d_v, input logic [3:0] d, input logic e);
    @(negedge clk);
    dv = d_v; rxd = d; er = e;
    drv_cyc = cyc;
  endtask

  task automatic send_frame(input int f);
    vec_t        t;
    logic [7:0]  b [128];
    logic [31:0] c;
    int          npay;
    t = frames[f];
    npay = t.nbytes - 4;
    for (int i = 0; i < npay; i++) b[i] = 8'(i);
    // Reflected CRC-32, transmitted complemented, low byte first.
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) b[npay + k] = c[8*k +: 8];
    if (t.flip) b[3] = b[3] ^ 8'h10;
    for (int i = 0; i < t.nbytes; i++) exp_b[f][i] = b[i];
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5, t.er_pre && i > 0 && i < 4);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < t.nbytes; i++) begin
      nib(1'b1, b[i][3:0], i == t.er_byte);
      nib(1'b1, b[i][7:4], i == t.er_byte);
      if (i == 4) t_b4[f] = drv_cyc;
    end
    if (t.odd) nib(1'b1, 4'hA, 1'b0);
    repeat (t.gap) nib(1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_frame(input int g, input int f);
    vec_t        t;
    int          m, acc, words, bad;
    logic [3:0]  es;
    logic [31:0] ew;
    bit          ee;
    t = frames[f];
    m = (g == 0) ? 1522 : 64;
    acc = (t.nbytes > m) ? m : t.nbytes;
    words = (acc + 3) / 4;
    case (acc % 4)
      1: es = 4'h1;
      2: es = 4'h3;
      3: es = 4'h7;
      default: es = 4'hF;
    endcase
    ee = (t.er_byte >= 0 && t.er_byte < acc) || t.odd || (t.nbytes > m);
    chk($sformatf("words[%0d/%0d]", g, f), r_n[g][f], words);
    chk($sformatf("last_strb[%0d/%0d]", g, f), r_strb[g][f], es);
    chk($sformatf("error[%0d/%0d]", g, f), r_err[g][f], ee);
    if (t.nbytes <= m) chk($sformatf("crc_ok[%0d/%0d]", g, f), r_crc[g][f], !t.flip);
    chk($sformatf("latency[%0d/%0d]", g, f), r_first[g][f] - t_b4[f], 2);
    bad = 0;
    for (int w = 0; w < words && w < r_n[g][f] && w < 32; w++) begin
      for (int k = 0; k < 4; k++) ew[8*k +: 8] = (4*w + k < acc) ? exp_b[f][4*w + k] : 8'h00;
      if (r_w[g][f][w] !== ew) begin
        bad++;
        $display("FAIL data[%0d/%0d] word %0d: got %h, expected %h", g, f, w, r_w[g][f][w], ew);
      end
    end
    n_chk++;
    if (bad != 0) n_fail++;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 200 && (done[0] < n || done[1] < n); k++) @(negedge clk);
    chk("frames_done0", done[0], n);
    chk("frames_done1", done[1], n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    vecs[0] = '{64,  1'b0, -1, 1'b0, 1'b0, 12};  // good 64-byte frame
    vecs[1] = '{61,  1'b0, -1, 1'b0, 1'b0, 12};  // tail word with one byte
    vecs[2] = '{64,  1'b1, -1, 1'b0, 1'b0, 12};  // corrupted payload
    vecs[3] = '{64,  1'b0, 10, 1'b0, 1'b0, 12};  // rx_er on byte 10
    vecs[4] = '{64,  1'b0, -1, 1'b0, 1'b1, 12};  // rx_er in preamble only
    vecs[5] = '{64,  1'b0, -1, 1'b1, 1'b0, 12};  // odd nibble count
    vecs[6] = '{100, 1'b0, -1, 1'b0, 1'b0, 12};  // overlength on small instance
    vecs[7] = '{62,  1'b0, -1, 1'b0, 1'b0, 1};   // back-to-back pair
    vecs[8] = '{63,  1'b0, -1, 1'b0, 1'b0, 12};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_valid[%0d]", g), valid[g], 1'b0);
      chk($sformatf("rst_data[%0d]", g), data[g], 32'h0);
      chk($sformatf("rst_strb[%0d]", g), strb[g], 4'h0);
      chk($sformatf("rst_last[%0d]", g), last[g], 1'b0);
      chk($sformatf("rst_crc_ok[%0d]", g), crc_ok[g], 1'b0);
      chk($sformatf("rst_error[%0d]", g), error[g], 1'b0);
    end
    rst = 1'b0;
    repeat (2) nib(1'b0, 4'h0, 1'b0);

    for (int f = 0; f < NV; f++) begin
      frames[f] = vecs[f];
      send_frame(f);
    end
    wait_done(NV);
    for (int f = 0; f < NV; f++) begin
      check_frame(0, f);
      check_frame(1, f);
    end

    // Reset in the middle of a frame: nothing may complete, next frame decodes cleanly.
    d0 = done[0];
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      nib(1'b1, 4'h3, 1'b0);
      nib(1'b1, 4'h3, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) nib(1'b0, 4'h0, 1'b0);
    chk("rst_mid_valid", valid[0], 1'b0);
    rst = 1'b0;
    repeat (8) nib(1'b0, 4'h0, 1'b0);
    chk("rst_mid_no_last", done[0], d0);
    frames[NV] = '{64, 1'b0, -1, 1'b0, 1'b0, 12};
    send_frame(NV);
    wait_done(NV + 1);
    check_frame(0, NV);
    check_frame(1, NV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
